// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin arbiter/sequencer sharing one uart_tx byte
//             transmitter between NUM_REQ requesters. Latches the winner's
//             byte, holds tx_send_en for the whole frame, waits for tx_done
//             (or times out), reports back, then enforces an idle gap.
//  Ports    : clk, rst (async, active-high)
//             req[NUM_REQ]        per-requester transmit request (level)
//             req_data[8*NUM_REQ] byte of requester i at [8i+7:8i]
//             ack/done/err        one-hot pulses toward the owning requester
//             tx_send_en, tx_data to the transmitter; tx_done from it
//             busy                high whenever the arbiter is not idle
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic                   tx_send_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_gap  = 2'd2;

    localparam logic [15:0]      c_to_last  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] c_ptr_rst  = IDX_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_own;
    logic [15:0]        r_to_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;
    logic               r_send_en;
    logic [7:0]         r_tx_data;
    logic               r_busy;

    logic [IDX_W-1:0]   w_win;
    int                 w_dist;
    int                 w_best;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Winner = requesting index closest *after* the pointer (modulo NUM_REQ).
    // The pointer's own index has the largest distance, so the last-served
    // requester gets the lowest priority.
    always_comb begin
        w_win  = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i > int'(r_ptr)) begin
                w_dist = i - int'(r_ptr) - 1;
            end else begin
                w_dist = i + NUM_REQ - int'(r_ptr) - 1;
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_ptr     <= c_ptr_rst;
            r_own     <= '0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_send_en <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                c_idle: begin
                    if (|req) begin
                        r_own     <= w_win;
                        r_tx_data <= req_data[{w_win, 3'b000} +: 8];
                        r_ack     <= f_onehot(w_win);
                        r_send_en <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= c_busy;
                        r_busy    <= 1'b1;
                    end
                end
                c_busy: begin
                    r_to_cnt <= r_to_cnt + 16'd1;
                    // tx_done has priority over a coincident timeout terminal.
                    if (tx_done || (r_to_cnt == c_to_last)) begin
                        r_send_en <= 1'b0;
                        if (tx_done) begin
                            r_done <= f_onehot(r_own);
                        end else begin
                            r_err <= f_onehot(r_own);
                        end
                        r_ptr <= r_own;
                        if (GAP_CYCLES == 0) begin
                            r_state <= c_idle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_gap_cnt <= '0;
                            r_state   <= c_gap;
                        end
                    end
                end
                c_gap: begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= c_idle;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign done       = r_done;
    assign err        = r_err;
    assign tx_send_en = r_send_en;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Self-checking bench for uart_tx_arb. Two instances share the
//             request stimulus: one with a 16-cycle gap, one with no gap, both
//             with a 100-cycle timeout. A transaction-level reference model
//             predicts every output every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_data;
    logic [1:0]       tx_done;
    logic [1:0][N-1:0] ack_v, done_v, err_v;
    logic [1:0]       send_v, busy_v;
    logic [1:0][7:0]  txd_v;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(N), .GAP_CYCLES(16), .TIMEOUT_CYCLES(TO)) dut_gap (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack_v[0]), .done(done_v[0]), .err(err_v[0]),
        .tx_send_en(send_v[0]), .tx_data(txd_v[0]), .tx_done(tx_done[0]),
        .busy(busy_v[0]));

    uart_tx_arb #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_nogap (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack_v[1]), .done(done_v[1]), .err(err_v[1]),
        .tx_send_en(send_v[1]), .tx_data(txd_v[1]), .tx_done(tx_done[1]),
        .busy(busy_v[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per instance, the owner of the current frame (-1 none),
    // the frame's age in cycles since its ack, and remaining gap cycles.
    int         m_own [2];
    int         m_age [2];
    int         m_gap [2];
    int         m_ptr [2];
    int         m_lat [2];
    logic [7:0] m_data[2];
    logic [N-1:0] e_ack[2], e_done[2], e_err[2];
    int         lat_fixed;
    int         cyc;
    bit         rr_on;
    int         rr_q[2][$];
    int         last_done[2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 16 : 0;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1; m_age[d] = 0; m_gap[d] = 0; m_ptr[d] = N - 1;
            m_lat[d] = 0;  m_data[d] = 8'h00;
            e_ack[d] = '0; e_done[d] = '0; e_err[d] = '0;
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            e_ack[d] = '0; e_done[d] = '0; e_err[d] = '0;
            if (m_own[d] >= 0) begin
                if (tx_done[d] || (m_age[d] == TO - 1)) begin
                    if (tx_done[d]) e_done[d] = N'(1 << m_own[d]);
                    else            e_err[d]  = N'(1 << m_own[d]);
                    m_ptr[d] = m_own[d];
                    m_own[d] = -1;
                    m_gap[d] = gap_of(d);
                end else begin
                    m_age[d]++;
                end
            end else if (m_gap[d] > 0) begin
                m_gap[d]--;
            end else if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_ptr[d] + k) % N;
                    if (req[i] && m_own[d] < 0) begin
                        m_own[d]  = i;
                        m_age[d]  = 0;
                        m_data[d] = req_data[i*8 +: 8];
                        e_ack[d]  = N'(1 << i);
                        m_lat[d]  = (lat_fixed < 0) ? int'($urandom_range(1, 110)) : lat_fixed;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_ack", d),  32'(ack_v[d]),  32'(e_ack[d]));
            chk($sformatf("d%0d_done", d), 32'(done_v[d]), 32'(e_done[d]));
            chk($sformatf("d%0d_err", d),  32'(err_v[d]),  32'(e_err[d]));
            chk($sformatf("d%0d_send", d), 32'(send_v[d]), 32'(m_own[d] >= 0));
            chk($sformatf("d%0d_data", d), 32'(txd_v[d]),  32'(m_data[d]));
            chk($sformatf("d%0d_busy", d), 32'(busy_v[d]), 32'((m_own[d] >= 0) || (m_gap[d] > 0)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        if (rr_on) begin
            for (int d = 0; d < 2; d++) begin
                if (ack_v[d] != '0) begin
                    rr_q[d].push_back(oh_idx(ack_v[d]));
                    if (last_done[d] >= 0)
                        chk($sformatf("d%0d_done_to_ack", d), 32'(cyc - last_done[d]), 32'(gap_of(d) + 1));
                end
                if (done_v[d] != '0) last_done[d] = cyc;
            end
        end
    endtask

    // Apply inputs for the coming edge; the transmitter stand-in raises
    // tx_done when the frame reaches its chosen latency, and may inject
    // spurious pulses while no frame is in flight.
    task automatic drive(input logic [N-1:0] r, input logic [8*N-1:0] dat, input bit spurious);
        req      = r;
        req_data = dat;
        for (int d = 0; d < 2; d++)
            tx_done[d] = ((m_own[d] >= 0) && (m_age[d] == m_lat[d])) ||
                         (spurious && (m_own[d] < 0) && ($urandom_range(0, 3) == 0));
        model_step();
    endtask

    function automatic logic [8*N-1:0] rnd_data();
        return {$urandom, $urandom} >> 32;
    endfunction

    task automatic run(input int n, input int mode, input logic [N-1:0] r);
        for (int c = 0; c < n; c++) begin
            tick();
            case (mode)
                0:       drive(r, rnd_data(), 1'b0);
                default: drive(N'($urandom_range(0, 15)), rnd_data(), 1'b1);
            endcase
        end
    endtask

    initial begin
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        cyc = 0; rr_on = 0; lat_fixed = 20;
        last_done[0] = -1; last_done[1] = -1;
        rst = 1'b1; req = '0; req_data = '0; tx_done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        drive('0, '0, 1'b0);

        // Round-robin with every request held, transmitter answers at age 20.
        rr_on = 1;
        run(220, 0, 4'b1111);
        rr_on = 0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 5; k++)
                chk($sformatf("d%0d_rr_order%0d", d, k),
                    32'((k < rr_q[d].size()) ? rr_q[d][k] : -1), 32'(exp_rr[k]));
        run(60, 0, 4'b0000);

        // Single request from requester 2 carrying 0xA5.
        tick();
        drive(4'b0100, 32'h00A5_0000, 1'b0);
        tick();
        chk("single_ack", 32'(ack_v[0]), 32'h4);
        chk("single_data", 32'(txd_v[0]), 32'hA5);
        drive('0, rnd_data(), 1'b0);
        run(60, 0, 4'b0000);

        // Timeout: transmitter never answers.
        lat_fixed = 1000;
        run(260, 0, 4'b0011);
        run(130, 0, 4'b0000);

        // tx_done coincides with the timeout terminal.
        lat_fixed = TO - 1;
        tick();
        drive(4'b0100, rnd_data(), 1'b0);
        run(130, 0, 4'b0000);

        // Randomized traffic with spurious tx_done outside frames.
        lat_fixed = -1;
        run(3000, 1, 4'b0000);

        // Asynchronous reset in the middle of a frame.
        lat_fixed = 1000;
        run(40, 0, 4'b1000);
        tick();
        chk("pre_rst_busy", 32'(busy_v[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_send", d), 32'(send_v[d]), 32'h0);
            chk($sformatf("d%0d_rst_busy", d), 32'(busy_v[d]), 32'h0);
            chk($sformatf("d%0d_rst_pulses", d), 32'({ack_v[d], done_v[d], err_v[d]}), 32'h0);
        end
        model_reset();
        drive('0, '0, 1'b0);
        tick();
        rst = 1'b0;
        lat_fixed = 20;
        drive(4'b1111, rnd_data(), 1'b0);
        tick();
        chk("rst_first_grant", 32'(ack_v[0]), 32'h1);
        drive(4'b1111, rnd_data(), 1'b0);
        lat_fixed = -1;
        run(200, 1, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one `uart_tx` byte transmitter between `NUM_REQ` requesters. It latches the winning requester's byte and holds the transmitter's `send_en` level for the whole frame, since the transmitter only advances while `send_en` is high. It waits for `tx_done`, reports completion or timeout back to the owning requester, and enforces an inter-frame idle gap. It sits between the on-chip byte producers and the single `uart_tx` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 16: idle clk cycles inserted after every frame; 0 means no gap.
- `TIMEOUT_CYCLES`, 65535: clk cycles allowed from launch to `tx_done` before abort; 16-bit counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester transmit request, level.
- `req_data`  in  8*NUM_REQ  byte of requester i at `[8i+7:8i]`.
- `ack`  out  NUM_REQ  one-cycle pulse: requester i's byte latched; requester may drop `req`/change data.
- `done`  out  NUM_REQ  one-cycle pulse: requester i's frame completed.
- `err`  out  NUM_REQ  one-cycle pulse: requester i's frame aborted by timeout.
- `tx_send_en`  out  1  to transmitter `send_en`, held high for the whole frame.
- `tx_data`  out  8  to transmitter `data_byte`, stable while `tx_send_en`=1.
- `tx_done`  in  1  from transmitter, end-of-frame indication.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, BUSY, GAP. Reset: IDLE, all outputs 0, `tx_data`=0, round-robin pointer `ptr`=NUM_REQ-1, so requester 0 wins first.
- IDLE: if `req` != 0, pick the first set bit searching `ptr+1, ptr+2, …` modulo NUM_REQ. Register the winner index `own`. Latch `req_data[own]` into `tx_data`. Pulse `ack[own]`, set `tx_send_en`=1, clear the timeout counter, go to BUSY. If `req`=0, stay in IDLE.
- BUSY: the timeout counter increments each cycle.
  - `tx_done`=1: `tx_send_en`<=0, pulse `done[own]`, `ptr`<=`own`, go to GAP.
  - Else if counter == TIMEOUT_CYCLES-1: `tx_send_en`<=0, pulse `err[own]`, `ptr`<=`own`, go to GAP.
  - `tx_done` and the timeout terminal in the same cycle: `tx_done` wins, so `done` is pulsed and not `err`.
  - `req` changes in BUSY are ignored. The byte is already latched.
- GAP: the gap counter runs from 0. At count GAP_CYCLES-1, go to IDLE. If GAP_CYCLES=0, BUSY exits directly to IDLE, skipping GAP.
- `tx_done` sampled in IDLE or GAP is ignored.
- `ack`, `done` and `err` are one-hot or zero, and mutually exclusive per cycle.
- The pointer update only happens at frame end. The requester just served gets lowest priority for the next arbitration.
- Reset mid-frame: everything returns to reset values immediately and asynchronously. `tx_send_en` drops, which returns the transmitter's line to idle via its own `send_en` gating. No `done` or `err` is pulsed.

## Timing
- `req` sampled high at edge N (IDLE) -> `ack[own]`=1 and `tx_send_en`=1 after edge N, i.e. visible in cycle N+1.
- `tx_done` sampled high at edge M -> `tx_send_en`=0 and `done[own]`=1 in cycle M+1.
- Timeout: `err` is asserted TIMEOUT_CYCLES cycles after `ack`.
- Frame end to next `ack`: GAP_CYCLES+1 cycles minimum, because GAP lasts GAP_CYCLES cycles plus one IDLE arbitration cycle. With GAP_CYCLES=0 this is 1 cycle.
- `tx_data` changes only on `ack` cycles.
- `busy` is registered and tracks state.

## Test plan
- Single request: `req`=4'b0100, `req_data[23:16]`=8'hA5 -> `ack`=4'b0100 one cycle later, `tx_data`=8'hA5, `tx_send_en` high until the cycle after `tx_done`, then `done`=4'b0100 pulse, `busy` low after 16 GAP cycles plus 1.
- Round-robin: all four `req` held high, model answers `tx_done` 20 cycles after each launch -> grant order 0,1,2,3,0. Each `ack` is exactly 17 cycles after the preceding `done`.
- Timeout: TIMEOUT_CYCLES=100, `tx_done` never asserted -> `err[own]` is pulsed 100 cycles after `ack`, `tx_send_en` falls the same cycle, no `done`. The next requester is served after the gap.
- Simultaneous `tx_done` and timeout terminal at cycle 99 -> `done` pulsed, `err` stays 0.
- GAP_CYCLES=0 with `req`=4'b0011 held -> second `ack` (requester 1) one cycle after the first `done`. Spurious `tx_done` pulses injected in IDLE produce no output.
- `rst` asserted mid-BUSY -> `tx_send_en`, `busy`, `ack`/`done`/`err` are 0 immediately. After release, the first grant goes to requester 0 when `req`=4'b1111.
